// File: rtl/cache_test_sequencer_if.sv
// Cache request port between the test sequencer (master) and the cache (slave).
// The master holds a request stable while the cache raises cache_stall; a request
// is taken on the edge where cache_en=1 and cache_stall=0.
interface cache_test_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              cache_en;
  logic              cache_we;
  logic [ADDR_W-1:0] cache_addr;
  logic [31:0]       cache_din;
  logic              cache_stall;

  modport master (
    output cache_en, cache_we, cache_addr, cache_din,
    input  cache_stall
  );

  modport slave (
    input  cache_en, cache_we, cache_addr, cache_din,
    output cache_stall
  );
endinterface

// File: rtl/cache_test_sequencer.sv
// Walks the instruction ROM from index 0, issuing each valid read/write entry to
// the cache under a stall handshake, and stops at the first invalid entry, after
// the last ROM entry, or when one request stalls for TIMEOUT cycles. Reports
// done/err plus saturating cycle and stall statistics.
module cache_test_sequencer #(
  parameter int IDX_W   = 4,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic [IDX_W-1:0]     index_o,
  input  logic                 inst_valid_i,
  input  logic                 inst_write_i,
  input  logic [ADDR_W-1:0]    inst_addr_i,
  cache_test_sequencer_if.master cache,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [IDX_W:0]       inst_count_o,
  output logic [CNT_W-1:0]     cycle_count_o,
  output logic [CNT_W-1:0]     stall_count_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = '1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [31:0]       DIN_MASK  = 32'hA5A5_A5A5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cycle_count_d;
  logic [CNT_W-1:0]  stall_count_d;
  logic [31:0]       din_d;

  // Saturating next values for the statistics counters and the write-data pattern.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    cycle_count_d = (cycle_count_o == '1) ? cycle_count_o : cycle_count_o + CNT_W'(1);
    stall_count_d = (stall_count_o == '1) ? stall_count_o : stall_count_o + CNT_W'(1);
    din_d         = 32'(inst_addr_i) ^ DIN_MASK;
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      wait_q           <= '0;
      index_o          <= '0;
      cache.cache_en   <= 1'b0;
      cache.cache_we   <= 1'b0;
      cache.cache_addr <= '0;
      cache.cache_din  <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      inst_count_o     <= '0;
      cycle_count_o    <= '0;
      stall_count_o    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_q       <= S_FETCH;
            wait_q        <= '0;
            index_o       <= '0;
            inst_count_o  <= '0;
            cycle_count_o <= '0;
            stall_count_o <= '0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            busy_o        <= 1'b1;
          end
        end

        S_FETCH: begin
          cycle_count_o <= cycle_count_d;
          if (!inst_valid_i) begin
            state_q <= S_DONE;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            state_q          <= S_ISSUE;
            wait_q           <= '0;
            cache.cache_en   <= 1'b1;
            cache.cache_we   <= inst_write_i;
            cache.cache_addr <= inst_addr_i;
            cache.cache_din  <= din_d;
          end
        end

        S_ISSUE: begin
          cycle_count_o <= cycle_count_d;
          if (!cache.cache_stall) begin
            // Accepted: drop the request and move on, or finish after the last entry.
            cache.cache_en   <= 1'b0;
            cache.cache_we   <= 1'b0;
            cache.cache_addr <= '0;
            cache.cache_din  <= '0;
            inst_count_o     <= inst_count_o + (IDX_W+1)'(1);
            if (index_o == IDX_LAST) begin
              state_q <= S_DONE;
              done_o  <= 1'b1;
              busy_o  <= 1'b0;
            end else begin
              index_o <= index_o + IDX_W'(1);
              state_q <= S_FETCH;
            end
          end else begin
            wait_q        <= wait_q + WAIT_W'(1);
            stall_count_o <= stall_count_d;
            if (wait_q == WAIT_LAST) begin
              state_q          <= S_ERR;
              err_o            <= 1'b1;
              busy_o           <= 1'b0;
              cache.cache_en   <= 1'b0;
              cache.cache_we   <= 1'b0;
              cache.cache_addr <= '0;
              cache.cache_din  <= '0;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_test_sequencer.sv
// Self-checking bench for cache_test_sequencer. The bench plays the ROM and the
// cache; a per-request stall plan drives cache_stall, and a program-level model
// predicts the accepted requests, final flags, index and statistics.
module tb_cache_test_sequencer;

  localparam int IDX_W   = 4;
  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 24;
  localparam int N_ENT   = 1 << IDX_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int MAX_CYC = 2000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
  } req_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stall;
  logic [IDX_W-1:0]  index;
  logic              inst_valid, inst_write;
  logic [ADDR_W-1:0] inst_addr;
  logic              busy, done, err;
  logic [IDX_W:0]    inst_count;
  logic [CNT_W-1:0]  cycle_count, stall_count;

  logic              rom_valid [N_ENT];
  logic              rom_write [N_ENT];
  logic [31:0]       rom_addr  [N_ENT];

  int   plan[$];
  req_t exp_q[$];
  req_t obs_q[$];
  int   exp_cycles, exp_stalls, exp_count, exp_index;
  bit   exp_err;
  int   errors = 0;
  int   checks = 0;

  cache_test_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  assign bus.cache_stall = stall;
  assign inst_valid      = rom_valid[index];
  assign inst_write      = rom_write[index];
  assign inst_addr       = rom_addr[index];

  cache_test_sequencer #(
    .IDX_W(IDX_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .index_o(index),
    .inst_valid_i(inst_valid), .inst_write_i(inst_write), .inst_addr_i(inst_addr),
    .cache(bus), .busy_o(busy), .done_o(done), .err_o(err),
    .inst_count_o(inst_count), .cycle_count_o(cycle_count), .stall_count_o(stall_count)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int x);
    return (x > CNT_MAX) ? CNT_MAX : x;
  endfunction

  // Random ROM with the first nvalid entries valid.
  task automatic load_prog(input int nvalid);
    for (int i = 0; i < N_ENT; i++) begin
      rom_valid[i] = (i < nvalid);
      rom_write[i] = 1'($urandom_range(0, 1));
      rom_addr[i]  = $urandom;
    end
  endtask

  // Program-level prediction: walk valid entries, each costing FETCH + ISSUE + its stalls.
  task automatic model_run();
    int i = 0;
    int k = 0;
    int s;
    exp_q.delete();
    exp_err = 0; exp_count = 0; exp_cycles = 0; exp_stalls = 0;
    while (1) begin
      if (!rom_valid[i]) begin
        exp_cycles += 1;
        break;
      end
      s = (k < plan.size()) ? plan[k] : 0;
      if (s >= TIMEOUT) begin
        exp_cycles += 1 + TIMEOUT;
        exp_stalls += TIMEOUT;
        exp_err = 1;
        break;
      end
      exp_q.push_back('{we: rom_write[i], addr: rom_addr[i], din: rom_addr[i] ^ 32'hA5A5_A5A5});
      exp_cycles += 2 + s;
      exp_stalls += s;
      exp_count++;
      k++;
      if (i == N_ENT - 1) break;
      i++;
    end
    exp_index = i;
  endtask

  // Start a run, act as the cache following the stall plan, then compare everything.
  task automatic run_program(input string name, input bit poke_start);
    int   n = 0;
    int   k = 0;
    int   sdone = 0;
    int   s;
    req_t cur, held;
    model_run();
    obs_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(done || err) && n < MAX_CYC) begin
      if (bus.cache_en) begin
        cur = '{we: bus.cache_we, addr: bus.cache_addr, din: bus.cache_din};
        checks++;
        if (cur.din !== (cur.addr ^ 32'hA5A5_A5A5)) begin
          errors++;
          $display("FAIL %s din: got %h want %h", name, cur.din, cur.addr ^ 32'hA5A5_A5A5);
        end
        if (sdone > 0) begin
          checks++;
          if (cur !== held) begin
            errors++;
            $display("FAIL %s request_stable: got %h want %h", name, cur, held);
          end
        end else begin
          held = cur;
        end
        s = (k < plan.size()) ? plan[k] : 0;
        if (sdone < s) begin
          stall = 1'b1;
          sdone++;
        end else begin
          stall = 1'b0;
          obs_q.push_back(cur);
          k++;
          sdone = 0;
        end
      end else begin
        stall = 1'($urandom_range(0, 1));
      end
      start = (poke_start && n == 3);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++;
    if (n >= MAX_CYC) begin
      errors++;
      $display("FAIL %s run_bound: no done/err within %0d cycles", name, MAX_CYC);
    end
    checks++;
    if (n != exp_cycles) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, n, exp_cycles);
    end
    // Outputs must stay frozen while the cache input keeps toggling.
    repeat (3) begin
      stall = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s req_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        checks++;
        if (obs_q[j] !== exp_q[j]) begin
          errors++;
          $display("FAIL %s req[%0d]: got %h want %h", name, j, obs_q[j], exp_q[j]);
        end
      end
    end
    checks++;
    if ({done, err, busy} !== {!exp_err, exp_err, 1'b0}) begin
      errors++;
      $display("FAIL %s flags(done,err,busy): got %b%b%b want %b%b0", name, done, err, busy,
               !exp_err, exp_err);
    end
    checks++;
    if (inst_count !== (IDX_W+1)'(exp_count)) begin
      errors++;
      $display("FAIL %s inst_count: got %0d want %0d", name, inst_count, exp_count);
    end
    checks++;
    if (cycle_count !== CNT_W'(sat(exp_cycles))) begin
      errors++;
      $display("FAIL %s cycle_count: got %0d want %0d", name, cycle_count, sat(exp_cycles));
    end
    checks++;
    if (stall_count !== CNT_W'(sat(exp_stalls))) begin
      errors++;
      $display("FAIL %s stall_count: got %0d want %0d", name, stall_count, sat(exp_stalls));
    end
    checks++;
    if (index !== IDX_W'(exp_index)) begin
      errors++;
      $display("FAIL %s index: got %0d want %0d", name, index, exp_index);
    end
    checks++;
    if ({bus.cache_en, bus.cache_din} !== 33'd0) begin
      errors++;
      $display("FAIL %s idle_request: got en=%b din=%h want en=0 din=0", name, bus.cache_en,
               bus.cache_din);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({index, bus.cache_en, bus.cache_we, bus.cache_addr, bus.cache_din, busy, done, err,
         inst_count, cycle_count, stall_count} !== '0) begin
      errors++;
      $display("FAIL %s all_zero: got idx=%0d en=%b we=%b addr=%h din=%h busy=%b done=%b err=%b ic=%0d cc=%0d sc=%0d want all 0",
               name, index, bus.cache_en, bus.cache_we, bus.cache_addr, bus.cache_din, busy,
               done, err, inst_count, cycle_count, stall_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    load_prog(0);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_idle");
  endtask

  task automatic test_basic();
    load_prog(3);
    plan = '{0, 0, 0};
    run_program("basic", 1'b0);
    checks++;
    if ({cycle_count, inst_count, index} !== {CNT_W'(7), 5'd3, 4'd3}) begin
      errors++;
      $display("FAIL basic_literal: got cc=%0d ic=%0d idx=%0d want 7 3 3", cycle_count,
               inst_count, index);
    end
  endtask

  task automatic test_stall17();
    load_prog(1);
    rom_write[0] = 1'b0;
    rom_addr[0]  = 32'h0000_0004;
    plan = '{17};
    run_program("stall17", 1'b0);
    checks++;
    if (stall_count !== CNT_W'(17)) begin
      errors++;
      $display("FAIL stall17_literal: got %0d want 17", stall_count);
    end
  endtask

  task automatic test_write_din();
    load_prog(1);
    rom_write[0] = 1'b1;
    rom_addr[0]  = 32'h1000_0018;
    plan = '{3};
    run_program("write_din", 1'b0);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 32'h1000_0018, 32'hB5A5_A5BD}) begin
      errors++;
      $display("FAIL write_din_literal: got %0d reqs want we=1 addr=10000018 din=b5a5a5bd",
               obs_q.size());
    end
  endtask

  task automatic test_timeout();
    load_prog(2);
    plan = '{TIMEOUT - 1, 0};
    run_program("timeout_edge", 1'b0);
    plan = '{1000};
    run_program("timeout", 1'b0);
    plan = '{0, 0};
    run_program("timeout_rerun", 1'b0);
  endtask

  task automatic test_full();
    load_prog(N_ENT);
    plan = {};
    run_program("full", 1'b0);
    for (int i = 0; i < N_ENT; i++) plan.push_back(int'($urandom_range(0, 6)));
    run_program("full_sat", 1'b0);
  endtask

  task automatic test_reset_mid();
    load_prog(3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; stall = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cache_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: got en=%b want 1", bus.cache_en);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("reset_mid");
    @(negedge clk); rst = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_mid_idle");
  endtask

  task automatic test_back_to_back();
    load_prog(3);
    plan = '{1, 0, 2};
    run_program("start_ignored", 1'b1);
    run_program("restart_from_done", 1'b0);
  endtask

  task automatic test_random();
    int r;
    for (int t = 0; t < 25; t++) begin
      load_prog(int'($urandom_range(0, N_ENT)));
      plan = {};
      for (int i = 0; i < N_ENT; i++) begin
        r = int'($urandom_range(0, 29));
        plan.push_back((r == 0) ? TIMEOUT : (r < 15 ? 0 : int'($urandom_range(1, 5))));
      end
      run_program($sformatf("random%0d", t), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall17();
    test_write_din();
    test_timeout();
    test_full();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
